// File: rtl/bk_serial_sequencer.sv
// bk_serial_sequencer: feeds a NIBBLE-wide adder core one slice per cycle, LSB first,
// chaining carry through a register and returning the assembled WIDTH-bit sum.
module bk_serial_sequencer #(
    parameter int WIDTH  = 16,
    parameter int NIBBLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_cin,
    output logic [NIBBLE-1:0] add_a,
    output logic [NIBBLE-1:0] add_b,
    output logic              add_cin,
    input  logic [NIBBLE-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_cout,
    output logic              busy
);
    localparam int N  = WIDTH / NIBBLE;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry;
    logic [IW-1:0]    idx;

    assign in_ready  = ena && state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    // Result stays visible after hand-off until the next accept clears it
    assign out_sum   = sum_reg;
    assign out_cout  = carry;

    always_comb begin
        state_nx = state;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        if (state == IDLE && in_valid)
            state_nx = RUN;
        if (state == RUN) begin
            add_a   = a_reg[idx*NIBBLE +: NIBBLE];
            add_b   = b_reg[idx*NIBBLE +: NIBBLE];
            add_cin = carry;
            state_nx = idx == LAST ? DONE : RUN;
        end
        if (state == DONE && out_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
        end else if (ena) begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_reg   <= in_a;
                b_reg   <= in_b;
                carry   <= in_cin;
                idx     <= '0;
                sum_reg <= '0;
            end
            if (state == RUN) begin
                sum_reg[idx*NIBBLE +: NIBBLE] <= add_sum;
                carry <= add_cout;
                idx   <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bk_serial_sequencer.sv
// tb_bk_serial_sequencer: directed bench with a behavioural adder core and a result scoreboard.
module tb_bk_serial_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1, in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
    logic [15:0] in_a = '0, in_b = '0, out_sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout, in_ready, out_valid, out_cout, busy;
    int          tests = 0, fails = 0;
    logic [16:0] exp_q[$];

    bk_serial_sequencer #(.WIDTH(16), .NIBBLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    // Stand-in for the 4-bit adder core
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        exp_q.push_back(17'(a) + 17'(b) + 17'(c));
        tick;
        in_valid = 1'b0;
    endtask

    // Checks each slice presented to the core against an independent ripple model.
    task automatic slices(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic cy = c;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("add_a_s%0d", i), add_a, (a >> (4 * i)) & 16'hF);
            chk($sformatf("add_b_s%0d", i), add_b, (b >> (4 * i)) & 16'hF);
            chk($sformatf("add_cin_s%0d", i), add_cin, cy);
            cy = (((a >> (4 * i)) & 16'hF) + ((b >> (4 * i)) & 16'hF) + 16'(cy)) > 15;
            tick;
        end
    endtask

    task automatic collect(input string tag, input int lat);
        int n = 0;
        logic [16:0] e;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, out_sum, e[15:0]);
            chk({tag, "_cout"}, out_cout, e[16]);
            chk({tag, "_busy"}, busy, 1);
        end
    endtask

    task automatic release_chk(input string tag);
        tick;
        chk({tag, "_valid_low"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_cin", add_cin, 0);
        chk("rst_in_ready", in_ready, 1);
        ena = 1'b0;
        #1 chk("idle_ena_low_in_ready", in_ready, 0);
        ena = 1'b1;
        rst_n = 1'b1;

        send(16'h1234, 16'h4321, 1'b0);
        chk("run_in_ready", in_ready, 0);
        slices(16'h1234, 16'h4321, 1'b0);
        collect("t1", 0);
        release_chk("t1");
        chk("t1_retain_sum", out_sum, 16'h5555);

        send(16'hFFFF, 16'h0001, 1'b0);
        slices(16'hFFFF, 16'h0001, 1'b0);
        collect("t2", 0);
        release_chk("t2");

        send(16'h0000, 16'h0000, 1'b1);
        collect("t3a", 4);
        release_chk("t3a");
        send(16'h8000, 16'h8000, 1'b1);
        collect("t3b", 4);
        release_chk("t3b");

        out_ready = 1'b0;
        send(16'hABCD, 16'h1111, 1'b0);
        collect("bp", 4);
        in_a = 16'h0101; in_b = 16'h0202; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sum", out_sum, 16'hBCDE);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        release_chk("bp");
        chk("bp_retain_sum", out_sum, 16'hBCDE);

        send(16'h0FFF, 16'h0001, 1'b0);
        tick;
        tick;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("ena_frozen_add_a", add_a, 4'hF);
            chk("ena_frozen_cin", add_cin, 1);
            chk("ena_frozen_busy", busy, 1);
        end
        ena = 1'b1;
        collect("ena", 2);
        release_chk("ena");

        send(16'h1111, 16'h2222, 1'b0);
        tick;
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        void'(exp_q.pop_back());
        #2 rst_n = 1'b1;
        send(16'h0002, 16'h0003, 1'b0);
        collect("post_rst", 4);
        release_chk("post_rst");

        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
            collect("rand", 4);
            release_chk("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
